// File: rtl/scpad_pkg.sv
// Scratchpad shared constants and response types.
package scpad_pkg;
  localparam int SCPAD_NUM_COLS  = 32;
  localparam int SCPAD_ELEM_BITS = 16;
  localparam int SCPAD_ID_W      = 4;
  localparam int SCPAD_RSP_DEPTH = 4;

  typedef struct packed {
    logic [SCPAD_ID_W-1:0]                          id;
    logic [SCPAD_NUM_COLS-1:0]                      mask;
    logic [SCPAD_NUM_COLS-1:0][SCPAD_ELEM_BITS-1:0] data;
  } scpad_rsp_t;
endpackage

// File: rtl/scpad_rsp_collect_if.sv
// Request, bank-completion and row-response bundle for the response collector.
interface scpad_rsp_collect_if
  import scpad_pkg::*;
#(
  parameter int NUM_COLS  = SCPAD_NUM_COLS,
  parameter int ELEM_BITS = SCPAD_ELEM_BITS,
  parameter int ID_W      = SCPAD_ID_W
);
  logic                               req_valid;
  logic                               req_ready;
  logic [NUM_COLS-1:0]                req_mask;
  logic [ID_W-1:0]                    req_id;
  logic [NUM_COLS-1:0]                bank_done;
  logic [NUM_COLS-1:0][ELEM_BITS-1:0] bank_rdata;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [ID_W-1:0]                    rsp_id;
  logic [NUM_COLS-1:0]                rsp_mask;
  logic [NUM_COLS-1:0][ELEM_BITS-1:0] rsp_data;

  modport master (
    output req_valid, req_mask, req_id, bank_done, bank_rdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_mask, rsp_data
  );

  modport slave (
    input  req_valid, req_mask, req_id, bank_done, bank_rdata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_mask, rsp_data
  );
endinterface

// File: rtl/scpad_lane_fifo.sv
// Single-lane synchronous FIFO; head visible combinationally, push/pop take effect at the edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module scpad_lane_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/scpad_rsp_collect.sv
// Re-assembles per-bank completions into in-order row responses; valid one cycle after the last lane lands.
// rsp_valid and req_ready come from registers only; consumer stalls hold the head row stable.
module scpad_rsp_collect
  import scpad_pkg::*;
#(
  parameter int NUM_COLS  = SCPAD_NUM_COLS,
  parameter int ELEM_BITS = SCPAD_ELEM_BITS,
  parameter int DEPTH     = SCPAD_RSP_DEPTH,
  parameter int ID_W      = SCPAD_ID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  scpad_rsp_collect_if.slave     bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0]                    trk_id   [DEPTH];
  logic [NUM_COLS-1:0]                trk_mask [DEPTH];
  logic [AW-1:0]                      head_ptr;
  logic [AW-1:0]                      tail_ptr;
  logic [NUM_COLS-1:0]                head_mask;
  logic [NUM_COLS-1:0]                full;
  logic [NUM_COLS-1:0]                empty;
  logic [NUM_COLS-1:0]                pop;
  logic [NUM_COLS-1:0][ELEM_BITS-1:0] lane_head;
  logic                               accept;
  logic                               retire;

  assign head_mask     = trk_mask[head_ptr];
  // DEPTH is a power of two, so the occupancy MSB alone means "full".
  assign bus.req_ready = ~outstanding[AW];
  assign bus.rsp_valid = (outstanding != '0) && ((head_mask & empty) == '0);
  assign bus.rsp_id    = trk_id[head_ptr];
  assign bus.rsp_mask  = head_mask;
  assign accept        = bus.req_valid && bus.req_ready;
  assign retire        = bus.rsp_valid && bus.rsp_ready;
  assign pop           = retire ? head_mask : '0;

  always_comb begin
    bus.rsp_data = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (head_mask[i]) bus.rsp_data[i] = lane_head[i];
    end
  end

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_lane
    scpad_lane_fifo #(
      .W     (ELEM_BITS),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.bank_done[g]),
      .pop   (pop[g]),
      .din   (bus.bank_rdata[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (lane_head[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      outstanding  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (accept) tail_ptr <= tail_ptr + 1'b1;
      if (retire) head_ptr <= head_ptr + 1'b1;
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      // A completion is lost only when its lane is full and not draining this cycle.
      if ((bus.bank_done & full & ~pop) != '0) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      trk_id[tail_ptr]   <= bus.req_id;
      trk_mask[tail_ptr] <= bus.req_mask;
    end
  end
endmodule

// File: tb/tb_scpad_rsp_collect.sv
// Bench for scpad_rsp_collect: directed table, hand sequences and random traffic against a queue model.
module tb_scpad_rsp_collect;
  import scpad_pkg::*;

  localparam int NC = SCPAD_NUM_COLS;
  localparam int EB = SCPAD_ELEM_BITS;
  localparam int D  = SCPAD_RSP_DEPTH;
  localparam int IW = SCPAD_ID_W;
  localparam int OW = $clog2(D) + 1;
  localparam int DW = NC * EB;

  logic clk = 1'b0;
  logic rst;
  logic [OW-1:0] outstanding;
  logic err_overflow;

  always #5 clk = ~clk;

  scpad_rsp_collect_if #(.NUM_COLS(NC), .ELEM_BITS(EB), .ID_W(IW)) bus ();

  scpad_rsp_collect #(
    .NUM_COLS (NC),
    .ELEM_BITS(EB),
    .DEPTH    (D),
    .ID_W     (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .outstanding (outstanding),
    .err_overflow(err_overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: request queue plus one data queue per lane.
  typedef struct {
    logic [IW-1:0] id;
    logic [NC-1:0] mask;
  } req_t;
  typedef logic [EB-1:0] lq_t[$];

  req_t m_req[$];
  lq_t  m_lane[NC];
  bit   m_ovf;

  function automatic bit m_valid();
    if (m_req.size() == 0) return 1'b0;
    for (int g = 0; g < NC; g++)
      if (m_req[0].mask[g] && m_lane[g].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic scpad_rsp_t m_head();
    scpad_rsp_t r;
    r = '0;
    r.id   = m_req[0].id;
    r.mask = m_req[0].mask;
    for (int g = 0; g < NC; g++)
      if (r.mask[g]) r.data[g] = m_lane[g][0];
    return r;
  endfunction

  function automatic void m_edge();
    bit ret;
    bit acc;
    logic [NC-1:0] popm;
    if (rst) begin
      m_req.delete();
      for (int g = 0; g < NC; g++) m_lane[g].delete();
      m_ovf = 1'b0;
    end else begin
      ret  = m_valid() && bus.rsp_ready;
      acc  = bus.req_valid && (m_req.size() < D);
      popm = ret ? m_req[0].mask : '0;
      for (int g = 0; g < NC; g++) begin
        if (popm[g]) void'(m_lane[g].pop_front());
        if (bus.bank_done[g]) begin
          if (m_lane[g].size() < D) m_lane[g].push_back(bus.bank_rdata[g]);
          else m_ovf = 1'b1;
        end
      end
      if (ret) void'(m_req.pop_front());
      if (acc) m_req.push_back('{id: bus.req_id, mask: bus.req_mask});
    end
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    scpad_rsp_t e;
    chk("req_ready", DW'(bus.req_ready), DW'(m_req.size() < D));
    chk("outstanding", DW'(outstanding), DW'(m_req.size()));
    chk("rsp_valid", DW'(bus.rsp_valid), DW'(m_valid()));
    chk("err_overflow", DW'(err_overflow), DW'(m_ovf));
    if (m_valid()) begin
      e = m_head();
      chk("rsp_id", DW'(bus.rsp_id), DW'(e.id));
      chk("rsp_mask", DW'(bus.rsp_mask), DW'(e.mask));
      chk("rsp_data", bus.rsp_data, e.data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_mask   = '0;
    bus.bank_done  = '0;
    bus.bank_rdata = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  typedef struct {
    bit            rv;
    logic [IW-1:0] rid;
    logic [NC-1:0] rmask;
    logic [NC-1:0] done;
    bit            rr;
    bit            ev;
    int            eo;
    logic [IW-1:0] eid;
    logic [NC-1:0] em;
  } vec_t;

  vec_t tbl[14];
  logic [NC-1:0][EB-1:0] exp_row;
  logic [NC-1:0][EB-1:0] zrow;

  initial begin
    // skew: id1 mask 0x3, lane0 at row 2, lane1 at row 6 -> valid after edge 6
    tbl[0]  = '{1'b1, 4'd1, 32'h3, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[1]  = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[2]  = '{1'b0, 4'd0, 32'h0, 32'h1, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[3]  = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[4]  = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[5]  = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[6]  = '{1'b0, 4'd0, 32'h0, 32'h2, 1'b0, 1'b1, 1, 4'd1, 32'h3};
    tbl[7]  = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 4'd0, 32'h0};
    // ordering: id1 on lane0, id2 on lane1, lane1 finishes first
    tbl[8]  = '{1'b1, 4'd1, 32'h1, 32'h0, 1'b0, 1'b0, 1, 4'd0, 32'h0};
    tbl[9]  = '{1'b1, 4'd2, 32'h2, 32'h0, 1'b0, 1'b0, 2, 4'd0, 32'h0};
    tbl[10] = '{1'b0, 4'd0, 32'h0, 32'h2, 1'b0, 1'b0, 2, 4'd0, 32'h0};
    tbl[11] = '{1'b0, 4'd0, 32'h0, 32'h1, 1'b0, 1'b1, 2, 4'd1, 32'h1};
    tbl[12] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1, 4'd2, 32'h2};
    tbl[13] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 4'd0, 32'h0};

    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    chk("reset_req_ready", DW'(bus.req_ready), DW'(1));
    chk("reset_outstanding", DW'(outstanding), DW'(0));
    chk("reset_err", DW'(err_overflow), DW'(0));
    rst = 1'b0;

    // full-row request, all banks complete together
    bus.req_valid = 1'b1; bus.req_id = 4'd3; bus.req_mask = '1;
    step();
    idle();
    chk("full_row_wait", DW'(bus.rsp_valid), DW'(0));
    bus.bank_done = '1;
    for (int g = 0; g < NC; g++) begin
      bus.bank_rdata[g] = EB'(g);
      exp_row[g]        = EB'(g);
    end
    step();
    idle();
    chk("full_row_valid", DW'(bus.rsp_valid), DW'(1));
    chk("full_row_id", DW'(bus.rsp_id), DW'(3));
    chk("full_row_data", bus.rsp_data, exp_row);
    bus.rsp_ready = 1'b1;
    step();
    idle();
    chk("full_row_retired", DW'(outstanding), DW'(0));

    for (int i = 0; i < 14; i++) begin
      bus.req_valid = tbl[i].rv;
      bus.req_id    = tbl[i].rid;
      bus.req_mask  = tbl[i].rmask;
      bus.bank_done = tbl[i].done;
      bus.rsp_ready = tbl[i].rr;
      for (int g = 0; g < NC; g++) bus.bank_rdata[g] = EB'(i * 256 + g + 1);
      step();
      chk("tbl_valid", DW'(bus.rsp_valid), DW'(tbl[i].ev));
      chk("tbl_outstanding", DW'(outstanding), DW'(tbl[i].eo));
      if (tbl[i].ev) begin
        chk("tbl_id", DW'(bus.rsp_id), DW'(tbl[i].eid));
        zrow = bus.rsp_data;
        for (int g = 0; g < NC; g++)
          if (tbl[i].em[g]) zrow[g] = '0;
        chk("tbl_unmasked_zero", zrow, '0);
      end
    end
    idle();

    // zero mask: valid right after accept
    bus.req_valid = 1'b1; bus.req_id = 4'd5; bus.req_mask = '0;
    step();
    idle();
    chk("zero_mask_valid", DW'(bus.rsp_valid), DW'(1));
    chk("zero_mask_id", DW'(bus.rsp_id), DW'(5));
    chk("zero_mask_data", bus.rsp_data, '0);
    bus.rsp_ready = 1'b1;
    step();
    idle();

    // backpressure: fill with consumer stalled
    for (int k = 0; k < D; k++) begin
      bus.req_valid = 1'b1; bus.req_id = IW'(8 + k); bus.req_mask = 32'h1;
      bus.bank_done = 32'h1; bus.bank_rdata[0] = EB'(16'h0B00 + k);
      step();
    end
    bus.bank_done = '0;
    bus.req_id    = 4'd12;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_req_ready", DW'(bus.req_ready), DW'(0));
      chk("bp_outstanding", DW'(outstanding), DW'(D));
      chk("bp_head_id", DW'(bus.rsp_id), DW'(8));
      chk("bp_head_data", DW'(bus.rsp_data[0]), DW'(16'h0B00));
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_id        = IW'(12 + k);
      bus.bank_done     = (m_req.size() < D) ? 32'h1 : 32'h0;
      bus.bank_rdata[0] = EB'(16'h0C00 + k);
      step();
      chk("bp_flow_range", DW'(outstanding >= 3 && outstanding <= 4), DW'(1));
    end
    bus.req_valid = 1'b0;
    bus.bank_done = '0;
    for (int k = 0; k < 6; k++) step();
    chk("bp_drained", DW'(outstanding), DW'(0));
    idle();

    // overflow on lane 0 with the consumer stalled
    for (int k = 0; k < D; k++) begin
      bus.req_valid = 1'b1; bus.req_id = IW'(k); bus.req_mask = 32'h1;
      bus.bank_done = 32'h1; bus.bank_rdata[0] = EB'(16'h0D00 + k);
      step();
    end
    chk("ovf_not_yet", DW'(err_overflow), DW'(0));
    bus.req_valid = 1'b0;
    bus.bank_rdata[0] = 16'h0DFF;
    step();
    chk("ovf_set", DW'(err_overflow), DW'(1));
    bus.bank_done = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("ovf_sticky", DW'(err_overflow), DW'(1));
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_id = 4'd9; bus.req_mask = 32'h1;
    bus.bank_done = 32'h1;
    rst = 1'b1;
    step();
    chk("rst_mid_valid", DW'(bus.rsp_valid), DW'(0));
    chk("rst_mid_outstanding", DW'(outstanding), DW'(0));
    chk("rst_mid_err", DW'(err_overflow), DW'(0));
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_quiet", DW'(bus.rsp_valid), DW'(0));
    end

    // random traffic with legal completions only
    for (int c = 0; c < 3000; c++) begin
      int owed;
      rst           = ($urandom_range(399) == 0);
      bus.req_valid = ($urandom_range(1) == 1);
      bus.req_id    = IW'($urandom);
      case ($urandom_range(3))
        0:       bus.req_mask = '0;
        1:       bus.req_mask = '1;
        default: bus.req_mask = NC'($urandom & $urandom & $urandom);
      endcase
      bus.rsp_ready = ($urandom_range(9) < 7);
      for (int g = 0; g < NC; g++) begin
        owed = 0;
        foreach (m_req[q]) if (m_req[q].mask[g]) owed++;
        owed = owed - m_lane[g].size();
        bus.bank_done[g]  = (owed > 0) && ($urandom_range(2) == 0);
        bus.bank_rdata[g] = EB'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scpad_rsp_collect.md
Name: scpad_rsp_collect

Overview:
- Downstream stage of the scratchpad SRAM bank array, upstream of the read crossbar.
- Re-assembles per-bank read completions into whole-row responses, in request issue order, with a valid/ready handshake to the consumer.
- Absorbs bank-to-bank skew: each bank may finish late while busy, and different banks finish in different cycles.
- Keeps an in-order tracker of outstanding read requests, plus one small FIFO per bank column.

Parameters:
- NUM_COLS, 32, number of bank columns (lanes) per row
- ELEM_BITS, 16, data width of one lane
- DEPTH, 4, maximum outstanding row requests; also the depth of each lane FIFO (power of two, >= 2)
- ID_W, 4, width of the request tag

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  row read issued to the banks this cycle
- req_ready  out  1  tracker can accept a request
- req_mask  in  NUM_COLS  lanes that will return data for this request
- req_id  in  ID_W  tag returned with the response
- bank_done  in  NUM_COLS  per-lane read completion strobe
- bank_rdata  in  NUM_COLS x ELEM_BITS  per-lane read data, valid with bank_done
- rsp_valid  out  1  assembled row available
- rsp_ready  in  1  consumer accepts the row
- rsp_id  out  ID_W  tag of the head request
- rsp_mask  out  NUM_COLS  mask of the head request
- rsp_data  out  NUM_COLS x ELEM_BITS  assembled row; unmasked lanes are 0
- outstanding  out  $clog2(DEPTH)+1  current tracker occupancy
- err_overflow  out  1  sticky: a bank_done arrived while that lane FIFO was full

Behaviour:
- Reset (rst high at a clk edge):
  - tracker and all lane FIFOs are emptied; err_overflow = 0; outstanding = 0.
  - rsp_valid = 0 and req_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight data; no response for a pre-reset request is ever emitted.
- Request accept:
  - Occurs when req_valid && req_ready.
  - {req_id, req_mask} is written at the tracker tail and outstanding increments.
  - req_ready = (outstanding < DEPTH). It is registered-state only and does not depend on rsp_ready (no combinational path from rsp_ready).
- Lane capture:
  - bank_done[g] pushes bank_rdata[g] into lane FIFO g, independent of any request.
  - Bank order within a lane is guaranteed by construction: the k-th completion on lane g belongs to the k-th outstanding request whose mask has bit g set.
- Head assembly: rsp_valid = tracker non-empty AND, for every g with head_mask[g] = 1, lane FIFO g is non-empty. rsp_valid is a function of registers only.
- Retire:
  - Occurs when rsp_valid && rsp_ready.
  - Pops the tracker head and pops lane FIFO g for every g in head_mask; outstanding decrements.
  - rsp_data[g] = FIFO g head if head_mask[g], else 0.
- Latency:
  - A completion at edge t makes rsp_valid visible in cycle t+1, provided it was the last missing lane of the head.
  - A request with req_mask = 0 becomes valid the cycle after it reaches the head.
- Simultaneous events:
  - Accept and retire in the same cycle: outstanding is unchanged.
  - Push and pop of the same lane FIFO in the same cycle are both performed; a full FIFO that is popped accepts the push.
- Boundaries:
  - Tracker full: req_ready = 0.
  - Lane FIFO full, bank_done[g] = 1, and no pop of lane g this cycle: data is dropped and err_overflow is set until reset.
  - Pointers wrap modulo DEPTH.
- rsp_id / rsp_mask / rsp_data are don't-care while rsp_valid = 0; they are held stable while rsp_valid && !rsp_ready.

Decomposition:
- scpad_pkg gains scpad_rsp_t {id, mask, data[NUM_COLS]} and SCPAD_RSP_DEPTH.
- NUM_COLS and ELEM_BITS defaults are taken from the existing scpad_pkg constants.
- Sub-module scpad_lane_fifo: single-lane synchronous FIFO with push, pop, full, empty and head data. It is instantiated NUM_COLS times. The tracker is an inline ring buffer.

Test Plan:
- Reset, then issue 1 request (id=3, mask=all-ones); all banks return data 0x00gg at the same edge -> rsp_valid one cycle later, rsp_id=3, lane g = 0x00gg.
- Skew: request id=1 mask=0x3; lane0 completes at cycle 2, lane1 at cycle 6 -> rsp_valid first high at cycle 7, lanes 2..31 = 0.
- Ordering: ids 1 (mask 0x1) and 2 (mask 0x2); lane1 completes before lane0 -> id=2 is withheld until id=1 retires; outputs appear as id 1 then id 2.
- Backpressure: fill DEPTH=4 requests with rsp_ready=0 -> req_ready=0, outstanding=4, head stable. Then hold rsp_ready=1 while req_valid=1 -> one retire and one accept per cycle, outstanding stays 3–4.
- Zero mask: request id=5 mask=0 on an empty tracker -> rsp_valid in the next cycle with rsp_data = 0.
- Overflow: 5 completions on lane 0 with mask-0x1 requests stalled -> err_overflow=1 and stays 1 until rst. Then assert rst mid-stream -> rsp_valid=0, outstanding=0, err_overflow=0 the next cycle.
